// File: rtl/mux_2x1_if.sv
// mux_2x1_if: bundles the data/select/handshake signals of mux_2x1.
//   master : source side, drives a, b, sel, in_valid and observes the results.
//   slave  : selector side, consumes the inputs and drives y, y_q, out_valid,
//            sel_a_cnt.
// WIDTH sets the data width and CNT_WIDTH the width of the debug counter. Both
// must match the parameters of the mux_2x1 instance the interface connects to.
interface mux_2x1_if #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 sel;
  logic                 in_valid;
  logic [WIDTH-1:0]     y;
  logic [WIDTH-1:0]     y_q;
  logic                 out_valid;
  logic [CNT_WIDTH-1:0] sel_a_cnt;

  modport master (
    output a, b, sel, in_valid,
    input  y, y_q, out_valid, sel_a_cnt
  );

  modport slave (
    input  a, b, sel, in_valid,
    output y, y_q, out_valid, sel_a_cnt
  );
endinterface

// File: rtl/mux_2x1.sv
// mux_2x1: parameterised 2:1 data selector (sel=1 -> a, sel=0 -> b).
//   clk           : rising-edge clock for the register stage.
//   rst_n         : asynchronous active-low reset of y_q, out_valid, sel_a_cnt.
//   bus.a/b       : data sources (WIDTH bits).
//   bus.sel       : select, 1 picks a, 0 picks b.
//   bus.in_valid  : qualifies a/b/sel for capture; every valid cycle is taken.
//   bus.y         : combinational selection, independent of clk and rst_n.
//   bus.y_q       : registered selection of the last accepted transfer.
//   bus.out_valid : high for the one cycle following each accepted transfer.
//   bus.sel_a_cnt : saturating count of accepted transfers that chose a.
module mux_2x1 #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_2x1_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     sel_data;
  logic [WIDTH-1:0]     data_d,  data_q;
  logic                 valid_d, valid_q;
  logic [CNT_WIDTH-1:0] cnt_d,   cnt_q;

  // The conditional operator merges a and b bitwise when sel is unknown, so
  // an X/Z select shows up as X on every bit where a and b differ.
  assign sel_data = bus.sel ? bus.a : bus.b;

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (bus.in_valid) begin
      data_d  = sel_data;
      valid_d = 1'b1;
      // Hold at all-ones instead of wrapping so the debug count never lies low.
      if (bus.sel && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.y         = sel_data;
  assign bus.y_q       = data_q;
  assign bus.out_valid = valid_q;
  assign bus.sel_a_cnt = cnt_q;

endmodule

// File: tb/tb_mux_2x1.sv
`timescale 1ns/1ps
// tb_mux_2x1: three instances of mux_2x1 sharing one clock and reset:
//   u_w1  : WIDTH=1, CNT_WIDTH=16  (truth table, unknown select)
//   u_w8  : WIDTH=8, CNT_WIDTH=16  (pulse, back-to-back, async reset)
//   u_sat : WIDTH=1, CNT_WIDTH=2   (counter saturation)
// Expected register-stage results are pushed to a queue when stimulus is
// driven and popped after the capturing edge.
module tb_mux_2x1;

  logic clk;
  logic rst_n;

  mux_2x1_if #(.WIDTH(1), .CNT_WIDTH(16)) bus1 ();
  mux_2x1_if #(.WIDTH(8), .CNT_WIDTH(16)) bus8 ();
  mux_2x1_if #(.WIDTH(1), .CNT_WIDTH(2))  bus_s ();

  mux_2x1 #(.WIDTH(1), .CNT_WIDTH(16)) u_w1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mux_2x1 #(.WIDTH(8), .CNT_WIDTH(16)) u_w8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  mux_2x1 #(.WIDTH(1), .CNT_WIDTH(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  yq;
    logic        ov;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for the WIDTH=8 instance.
  logic [7:0]  m_yq;
  logic [15:0] m_cnt;

  task automatic reset_model();
    m_yq  = '0;
    m_cnt = '0;
    sb.delete();
  endtask

  // Drive one cycle on the 8-bit instance, record the expected result of the
  // capturing edge, then step to just after that edge.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                        input logic sel, input logic v);
    exp_t e;
    bus8.a = a; bus8.b = b; bus8.sel = sel; bus8.in_valid = v;
    if (v) begin
      m_yq = sel ? a : b;
      if (sel && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    e.yq = m_yq; e.ov = v; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    #1;
  endtask

  task automatic test_reset();
    bus1.a = 0; bus1.b = 0; bus1.sel = 0; bus1.in_valid = 0;
    bus8.a = 0; bus8.b = 0; bus8.sel = 0; bus8.in_valid = 0;
    bus_s.a = 0; bus_s.b = 0; bus_s.sel = 0; bus_s.in_valid = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus8.y_q !== 8'h00 || bus8.out_valid !== 1'b0 || bus8.sel_a_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_w8: y_q=%h out_valid=%b cnt=%0d, required 00/0/0",
               bus8.y_q, bus8.out_valid, bus8.sel_a_cnt);
    end
    n_checks++;
    if (bus_s.y_q !== 1'b0 || bus_s.out_valid !== 1'b0 || bus_s.sel_a_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_sat: y_q=%b out_valid=%b cnt=%0d, required 0/0/0",
               bus_s.y_q, bus_s.out_valid, bus_s.sel_a_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    $display("reset: outputs cleared while rst_n low");
  endtask

  task automatic test_truth_table();
    logic [3:0] tt [7];   // {a, b, sel, y}
    tt[0] = 4'b0000; tt[1] = 4'b0110; tt[2] = 4'b1000; tt[3] = 4'b1101;
    tt[4] = 4'b1011; tt[5] = 4'b0010; tt[6] = 4'b1111;
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus1.a = tt[i][3]; bus1.b = tt[i][2]; bus1.sel = tt[i][1];
      #1;
      n_checks++;
      if (bus1.y !== tt[i][0]) begin
        n_fail++;
        $display("FAIL truth_y[%0d]: a=%b b=%b sel=%b y=%b, required %b",
                 i, tt[i][3], tt[i][2], tt[i][1], bus1.y, tt[i][0]);
      end
      n_checks++;
      if (bus1.y_q !== 1'b0 || bus1.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL truth_idle[%0d]: y_q=%b out_valid=%b, required 0/0",
                 i, bus1.y_q, bus1.out_valid);
      end
      $display("truth[%0d]: a=%b b=%b sel=%b -> y=%b", i, tt[i][3], tt[i][2], tt[i][1], bus1.y);
      #3;
    end
  endtask

  task automatic test_pulse();
    exp_t e;
    drive8(8'hA5, 8'h3C, 1'b1, 1'b1);
    e = sb.pop_front();
    n_checks++;
    if (bus8.y_q !== e.yq || bus8.out_valid !== e.ov || e.yq !== 8'hA5) begin
      n_fail++;
      $display("FAIL pulse_capture: y_q=%h out_valid=%b, required A5/1", bus8.y_q, bus8.out_valid);
    end
    $display("pulse: captured y_q=%h out_valid=%b", bus8.y_q, bus8.out_valid);
    drive8(8'hA5, 8'h3C, 1'b1, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (bus8.y_q !== e.yq || bus8.out_valid !== e.ov) begin
      n_fail++;
      $display("FAIL pulse_hold: y_q=%h out_valid=%b, required %h/%b",
               bus8.y_q, bus8.out_valid, e.yq, e.ov);
    end
    $display("pulse: hold y_q=%h out_valid=%b", bus8.y_q, bus8.out_valid);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [2:0] sels;
    sels = 3'b010;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive8(8'h11, 8'h22, sels[i], 1'b1);
      e = sb.pop_front();
      n_checks++;
      if (bus8.y_q !== e.yq || bus8.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: y_q=%h out_valid=%b, required %h/1",
                 i, bus8.y_q, bus8.out_valid, e.yq);
      end
      $display("b2b[%0d]: sel=%b y_q=%h out_valid=%b", i, sels[i], bus8.y_q, bus8.out_valid);
    end
    n_checks++;
    if (bus8.sel_a_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL b2b_cnt: sel_a_cnt=%0d, required 1", bus8.sel_a_cnt);
    end
    drive8(8'h11, 8'h22, 1'b1, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (bus8.out_valid !== 1'b0 || bus8.y_q !== e.yq || bus8.sel_a_cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL b2b_idle: y_q=%h out_valid=%b cnt=%0d, required %h/0/%0d",
               bus8.y_q, bus8.out_valid, bus8.sel_a_cnt, e.yq, e.cnt);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive8(8'h11, 8'h22, 1'b1, 1'b1);
      e = sb.pop_front();
    end
    n_checks++;
    if (bus8.y_q !== 8'h11 || bus8.sel_a_cnt !== 16'd5 || e.cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL arst_setup: y_q=%h cnt=%0d, required 11/5", bus8.y_q, bus8.sel_a_cnt);
    end
    #3 rst_n = 1'b0;   // mid-cycle, well away from any edge
    #1;
    n_checks++;
    if (bus8.y_q !== 8'h00 || bus8.out_valid !== 1'b0 || bus8.sel_a_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL arst_clear: y_q=%h out_valid=%b cnt=%0d, required 00/0/0",
               bus8.y_q, bus8.out_valid, bus8.sel_a_cnt);
    end
    bus8.a = 8'h5A; bus8.b = 8'hC3; bus8.sel = 1'b0;
    #1;
    n_checks++;
    if (bus8.y !== 8'hC3) begin
      n_fail++;
      $display("FAIL arst_comb: y=%h, required C3", bus8.y);
    end
    bus8.sel = 1'b1; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus8.y !== 8'h5A || bus8.y_q !== 8'h00 || bus8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_edge: y=%h y_q=%h out_valid=%b, required 5A/00/0",
               bus8.y, bus8.y_q, bus8.out_valid);
    end
    $display("arst: y_q=%h out_valid=%b cnt=%0d y=%h", bus8.y_q, bus8.out_valid, bus8.sel_a_cnt, bus8.y);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    #1;
    drive8(8'h77, 8'h01, 1'b1, 1'b1);
    e = sb.pop_front();
    n_checks++;
    if (bus8.y_q !== e.yq || bus8.out_valid !== 1'b1 || bus8.sel_a_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL arst_release: y_q=%h out_valid=%b cnt=%0d, required 77/1/1",
               bus8.y_q, bus8.out_valid, bus8.sel_a_cnt);
    end
    bus8.in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      bus_s.a = 1'b1; bus_s.b = 1'b0; bus_s.sel = 1'b1; bus_s.in_valid = 1'b1;
      e.yq = 8'h01; e.ov = 1'b1; e.cnt = (i + 1 > 3) ? 16'd3 : 16'(i + 1);
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus_s.sel_a_cnt !== e.cnt[1:0] || bus_s.y_q !== e.yq[0] || bus_s.out_valid !== e.ov) begin
        n_fail++;
        $display("FAIL sat[%0d]: cnt=%0d y_q=%b out_valid=%b, required %0d/%b/%b",
                 i, bus_s.sel_a_cnt, bus_s.y_q, bus_s.out_valid, e.cnt, e.yq[0], e.ov);
      end
      $display("sat[%0d]: sel_a_cnt=%0d", i, bus_s.sel_a_cnt);
    end
    bus_s.in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus_s.sel_a_cnt !== 2'd3 || bus_s.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_idle: cnt=%0d out_valid=%b, required 3/0", bus_s.sel_a_cnt, bus_s.out_valid);
    end
  endtask

  task automatic test_unknown_sel();
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.sel = 1'bx;
    #1;
    n_checks++;
    if ($isunknown(bus1.sel)) begin
      // Four-state simulator: the unknown select must propagate.
      if (!$isunknown(bus1.y)) begin
        n_fail++;
        $display("FAIL unknown_sel: y=%b, required x", bus1.y);
      end
    end else begin
      // Two-state simulator collapses X; y must still follow the resolved select.
      if (bus1.y !== (bus1.sel ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL unknown_sel_2state: sel=%b y=%b", bus1.sel, bus1.y);
      end
    end
    $display("unknown_sel: sel=%b y=%b", bus1.sel, bus1.y);
    bus1.sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_pulse();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    test_unknown_sel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
